// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one IO bus between two masters (m0 = core MEM port,
// m1 = DMA/debug loader). Round-robin grants with a bounded hold, combinational
// same-cycle grant, and a fixed-latency tagged read-return pipe.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 3,
    parameter int MAX_HOLD = 4,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [CTRL_W-1:0] m0_ctrl,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [CTRL_W-1:0] m1_ctrl,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [CTRL_W-1:0] bus_ctrl,
    output logic [DATA_W-1:0] bus_wd,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // hold_cnt counts extra beats after the first, so it never needs to exceed MAX_HOLD-1
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    state_t              state_r;
    state_t              state_s;
    logic                last_r;
    logic [HOLD_W-1:0]   hold_cnt_r;
    logic                gnt0_s;
    logic                gnt1_s;
    logic                hold_ok_s;
    logic                rd_load_s;
    logic                rv_out_s;
    logic [RD_LAT-1:0]   pipe_v_r;
    logic [RD_LAT-1:0]   pipe_id_r;

    // Arbitration: pick this cycle's winner from state, requests and last winner
    always_comb begin
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
        hold_ok_s = (hold_cnt_r < HOLD_MAX);
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        gnt0_s = last_r;
                        gnt1_s = ~last_r;
                    end else begin
                        gnt0_s = m0_req;
                        gnt1_s = m1_req;
                    end
                end
                OWN0: begin
                    if (m0_req && (hold_ok_s || !m1_req)) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = m1_req;
                    end
                end
                OWN1: begin
                    if (m1_req && (hold_ok_s || !m0_req)) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = m0_req;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Next state follows the granted master, IDLE when nobody is granted
    always_comb begin
        state_s = IDLE;
        if (gnt0_s) begin
            state_s = OWN0;
        end else if (gnt1_s) begin
            state_s = OWN1;
        end else begin
            state_s = IDLE;
        end
    end

    // Arbiter state: owner, last winner and saturating hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            last_r     <= 1'b1;
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (gnt0_s || gnt1_s) begin
                last_r <= gnt1_s;
                if ((gnt0_s && state_r == OWN0) || (gnt1_s && state_r == OWN1)) begin
                    if (hold_cnt_r == HOLD_MAX) begin
                        hold_cnt_r <= hold_cnt_r;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end else begin
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // Bus mux: drive the granted master's beat, zeros when idle
    always_comb begin
        bus_addr = {ADDR_W{1'b0}};
        bus_ctrl = {CTRL_W{1'b0}};
        bus_wd   = {DATA_W{1'b0}};
        bus_we   = 1'b0;
        if (gnt0_s) begin
            bus_addr = m0_addr;
            bus_ctrl = m0_ctrl;
            bus_wd   = m0_wd;
            bus_we   = m0_we;
        end else if (gnt1_s) begin
            bus_addr = m1_addr;
            bus_ctrl = m1_ctrl;
            bus_wd   = m1_wd;
            bus_we   = m1_we;
        end else begin
            bus_we   = 1'b0;
        end
    end

    assign rd_load_s = (gnt0_s & ~m0_we) | (gnt1_s & ~m1_we);

    // Read tag pipe: one {valid,id} per accepted read, shifted every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v_r  <= {RD_LAT{1'b0}};
            pipe_id_r <= {RD_LAT{1'b0}};
        end else begin
            pipe_v_r[0]  <= rd_load_s;
            pipe_id_r[0] <= gnt1_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_r[i]  <= pipe_v_r[i-1];
                pipe_id_r[i] <= pipe_id_r[i-1];
            end
        end
    end

    // Handshake and read-return outputs; everything forced quiet while in reset
    always_comb begin
        rv_out_s  = pipe_v_r[RD_LAT-1] & ~rst;
        m0_gnt    = gnt0_s;
        m1_gnt    = gnt1_s;
        m0_rvalid = rv_out_s & ~pipe_id_r[RD_LAT-1];
        m1_rvalid = rv_out_s & pipe_id_r[RD_LAT-1];
        m0_rd     = {DATA_W{1'b0}};
        m1_rd     = {DATA_W{1'b0}};
        if (m0_rvalid) begin
            m0_rd = bus_rd;
        end else if (m1_rvalid) begin
            m1_rd = bus_rd;
        end else begin
            m0_rd = {DATA_W{1'b0}};
        end
    end

endmodule
